rs_multi: RTL and testbench

- Parametrised reservation station for the out-of-order core. It sits between Dispatch and the ALU and is the successor of the single-CDB RS.
- Owns allocation itself: lowest-index free entry.
- Snoops CDB_N result buses for wakeup.
- Issues the oldest ready entry, ordered by ROB distance from the ROB head, over a valid/ready handshake with a registered output slot.

---
 rtl/rs_multi.sv | 204 ++++++++++++++++++++
 tb/tb_rs_multi.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_multi.sv
// Reservation station with multi-channel CDB snooping. Allocation goes to the lowest
// free entry, and issue picks the oldest ready entry by ROB distance from the head.
module rs_multi #(
  parameter int ENTRIES = 16,
  parameter int ROB_W   = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6,
  parameter int ADDR_W  = 32,
  parameter int CDB_N   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       clr,
  input  logic [ROB_W-1:0]           rob_head,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [DATA_W-1:0]          disp_a,
  input  logic [ADDR_W-1:0]          disp_pc,
  input  logic [ROB_W-1:0]           disp_tag,
  input  logic                       disp_qj_busy,
  input  logic                       disp_qk_busy,
  input  logic [DATA_W-1:0]          disp_vj,
  input  logic [DATA_W-1:0]          disp_vk,
  input  logic [CDB_N-1:0]           cdb_valid,
  input  logic [CDB_N*ROB_W-1:0]     cdb_tag,
  input  logic [CDB_N*DATA_W-1:0]    cdb_value,
  output logic                       alu_valid,
  input  logic                       alu_ready,
  output logic [OP_W-1:0]            alu_op,
  output logic [DATA_W-1:0]          alu_vj,
  output logic [DATA_W-1:0]          alu_vk,
  output logic [DATA_W-1:0]          alu_a,
  output logic [ADDR_W-1:0]          alu_pc,
  output logic [ROB_W-1:0]           alu_tag,
  output logic [$clog2(ENTRIES):0]   count,
  output logic                       full
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  logic              busy_r [ENTRIES];
  logic              qj_r   [ENTRIES];
  logic              qk_r   [ENTRIES];
  logic [OP_W-1:0]   op_r   [ENTRIES];
  logic [DATA_W-1:0] a_r    [ENTRIES];
  logic [ADDR_W-1:0] pc_r   [ENTRIES];
  logic [ROB_W-1:0]  tag_r  [ENTRIES];
  logic [DATA_W-1:0] vj_r   [ENTRIES];
  logic [DATA_W-1:0] vk_r   [ENTRIES];
  logic [CNT_W-1:0]  count_r;

  logic              alu_valid_r;
  logic [OP_W-1:0]   alu_op_r;
  logic [DATA_W-1:0] alu_vj_r;
  logic [DATA_W-1:0] alu_vk_r;
  logic [DATA_W-1:0] alu_a_r;
  logic [ADDR_W-1:0] alu_pc_r;
  logic [ROB_W-1:0]  alu_tag_r;

  logic [DATA_W:0]   wj_s   [ENTRIES];
  logic [DATA_W:0]   wk_s   [ENTRIES];
  logic              ready_s[ENTRIES];
  logic [ROB_W-1:0]  age_s  [ENTRIES];
  logic [DATA_W:0]   dj_s;
  logic [DATA_W:0]   dk_s;
  logic [IDX_W-1:0]  free_idx_s;
  logic [IDX_W-1:0]  sel_idx_s;
  logic [ROB_W-1:0]  sel_age_s;
  logic              sel_found_s;
  logic              full_s;
  logic              disp_acc_s;
  logic              issue_s;

  // Returns {hit, value}; channels scanned high-to-low so the lowest matching channel wins.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [ROB_W-1:0]        t,
    input logic [CDB_N-1:0]        v,
    input logic [CDB_N*ROB_W-1:0]  tags,
    input logic [CDB_N*DATA_W-1:0] vals
  );
    logic [DATA_W:0] hit;
    hit = '0;
    for (int c = CDB_N - 1; c >= 0; c--) begin
      hit = (v[c] && (tags[c*ROB_W +: ROB_W] == t)) ? {1'b1, vals[c*DATA_W +: DATA_W]} : hit;
    end
    return hit;
  endfunction

  // Wakeup lookups, free-entry search and oldest-ready selection from registered state.
  always_comb begin
    dj_s        = cdb_lookup(disp_vj[ROB_W-1:0], cdb_valid, cdb_tag, cdb_value);
    dk_s        = cdb_lookup(disp_vk[ROB_W-1:0], cdb_valid, cdb_tag, cdb_value);
    free_idx_s  = '0;
    sel_idx_s   = '0;
    sel_age_s   = '0;
    sel_found_s = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      free_idx_s = busy_r[i] ? free_idx_s : IDX_W'(i);
    end
    for (int i = 0; i < ENTRIES; i++) begin
      wj_s[i]    = cdb_lookup(vj_r[i][ROB_W-1:0], cdb_valid, cdb_tag, cdb_value);
      wk_s[i]    = cdb_lookup(vk_r[i][ROB_W-1:0], cdb_valid, cdb_tag, cdb_value);
      ready_s[i] = busy_r[i] && !qj_r[i] && !qk_r[i];
      age_s[i]   = tag_r[i] - rob_head;
      // Strict compare keeps the lowest index on (illegal) duplicate ages.
      if (ready_s[i] && (!sel_found_s || (age_s[i] < sel_age_s))) begin
        sel_found_s = 1'b1;
        sel_idx_s   = IDX_W'(i);
        sel_age_s   = age_s[i];
      end else begin
        sel_found_s = sel_found_s;
      end
    end
    full_s     = (count_r == CNT_W'(ENTRIES));
    disp_acc_s = disp_valid && !full_s;
    issue_s    = sel_found_s && (!alu_valid_r || alu_ready);
  end

  // Entry storage, occupancy and the registered issue slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        busy_r[i] <= 1'b0;
        qj_r[i]   <= 1'b0;
        qk_r[i]   <= 1'b0;
        op_r[i]   <= '0;
        a_r[i]    <= '0;
        pc_r[i]   <= '0;
        tag_r[i]  <= '0;
        vj_r[i]   <= '0;
        vk_r[i]   <= '0;
      end
      count_r     <= '0;
      alu_valid_r <= 1'b0;
      alu_op_r    <= '0;
      alu_vj_r    <= '0;
      alu_vk_r    <= '0;
      alu_a_r     <= '0;
      alu_pc_r    <= '0;
      alu_tag_r   <= '0;
    end else if (clr) begin
      for (int i = 0; i < ENTRIES; i++) begin
        busy_r[i] <= 1'b0;
      end
      count_r     <= '0;
      alu_valid_r <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (busy_r[i] && qj_r[i] && wj_s[i][DATA_W]) begin
          vj_r[i] <= wj_s[i][DATA_W-1:0];
          qj_r[i] <= 1'b0;
        end
        if (busy_r[i] && qk_r[i] && wk_s[i][DATA_W]) begin
          vk_r[i] <= wk_s[i][DATA_W-1:0];
          qk_r[i] <= 1'b0;
        end
      end
      // A freshly dispatched operand may be satisfied by a same-cycle broadcast.
      if (disp_acc_s) begin
        busy_r[free_idx_s] <= 1'b1;
        op_r[free_idx_s]   <= disp_op;
        a_r[free_idx_s]    <= disp_a;
        pc_r[free_idx_s]   <= disp_pc;
        tag_r[free_idx_s]  <= disp_tag;
        qj_r[free_idx_s]   <= disp_qj_busy && !dj_s[DATA_W];
        qk_r[free_idx_s]   <= disp_qk_busy && !dk_s[DATA_W];
        vj_r[free_idx_s]   <= (disp_qj_busy && dj_s[DATA_W]) ? dj_s[DATA_W-1:0] : disp_vj;
        vk_r[free_idx_s]   <= (disp_qk_busy && dk_s[DATA_W]) ? dk_s[DATA_W-1:0] : disp_vk;
      end
      if (issue_s) begin
        busy_r[sel_idx_s] <= 1'b0;
        alu_valid_r       <= 1'b1;
        alu_op_r          <= op_r[sel_idx_s];
        alu_vj_r          <= vj_r[sel_idx_s];
        alu_vk_r          <= vk_r[sel_idx_s];
        alu_a_r           <= a_r[sel_idx_s];
        alu_pc_r          <= pc_r[sel_idx_s];
        alu_tag_r         <= tag_r[sel_idx_s];
      end else if (alu_ready) begin
        alu_valid_r <= 1'b0;
      end else begin
        alu_valid_r <= alu_valid_r;
      end
      count_r <= count_r + CNT_W'(disp_acc_s) - CNT_W'(issue_s);
    end else begin
      count_r <= count_r;
    end
  end

  assign disp_ready = !full_s;
  assign full       = full_s;
  assign count      = count_r;
  assign alu_valid  = alu_valid_r;
  assign alu_op     = alu_op_r;
  assign alu_vj     = alu_vj_r;
  assign alu_vk     = alu_vk_r;
  assign alu_a      = alu_a_r;
  assign alu_pc     = alu_pc_r;
  assign alu_tag    = alu_tag_r;

endmodule

// File: tb/tb_rs_multi.sv
// Scoreboard bench for rs_multi: expected issues are queued at dispatch time and
// compared when the ALU handshake occurs; state checks cover flush, full and reset.
module tb_rs_multi;

  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic [3:0]  rob_head;
  logic        disp_valid, disp_ready;
  logic [5:0]  disp_op;
  logic [31:0] disp_a, disp_pc;
  logic [3:0]  disp_tag;
  logic        disp_qj_busy, disp_qk_busy;
  logic [31:0] disp_vj, disp_vk;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_value;
  logic        alu_valid, alu_ready;
  logic [5:0]  alu_op;
  logic [31:0] alu_vj, alu_vk, alu_a, alu_pc;
  logic [3:0]  alu_tag;
  logic [4:0]  count;
  logic        full;

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  tag;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] a;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  rs_multi dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .rob_head(rob_head),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_a(disp_a), .disp_pc(disp_pc), .disp_tag(disp_tag),
    .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
    .disp_vj(disp_vj), .disp_vk(disp_vk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
    .alu_vj(alu_vj), .alu_vk(alu_vk), .alu_a(alu_a), .alu_pc(alu_pc),
    .alu_tag(alu_tag), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [5:0] op, input logic [3:0] tag,
                          input logic [31:0] vj, input logic [31:0] vk);
    exp_t e;
    e.op  = op;
    e.tag = tag;
    e.vj  = vj;
    e.vk  = vk;
    e.a   = 32'h0000_1000 + {28'd0, tag};
    e.pc  = 32'h0000_4000 + {26'd0, tag, 2'b00};
    exp_q.push_back(e);
  endtask

  task automatic dispatch(input logic [5:0] op, input logic [3:0] tag,
                          input logic qjb, input logic [31:0] vj,
                          input logic qkb, input logic [31:0] vk);
    disp_valid   = 1'b1;
    disp_op      = op;
    disp_tag     = tag;
    disp_a       = 32'h0000_1000 + {28'd0, tag};
    disp_pc      = 32'h0000_4000 + {26'd0, tag, 2'b00};
    disp_qj_busy = qjb;
    disp_vj      = vj;
    disp_qk_busy = qkb;
    disp_vk      = vk;
    @(posedge clk); #1;
    disp_valid   = 1'b0;
  endtask

  task automatic cdb_pulse(input logic [1:0] v, input logic [3:0] t1, input logic [3:0] t0,
                           input logic [31:0] v1, input logic [31:0] v0);
    cdb_valid = v;
    cdb_tag   = {t1, t0};
    cdb_value = {v1, v0};
    @(posedge clk); #1;
    cdb_valid = 2'b00;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    check_eq("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: every handshake (valid && ready before the edge) must match the queue head.
  always @(negedge clk) begin
    if (rst && alu_valid && alu_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("iss_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("iss_tag", 64'(alu_tag), 64'(e.tag));
        check_eq("iss_op",  64'(alu_op),  64'(e.op));
        check_eq("iss_vj",  64'(alu_vj),  64'(e.vj));
        check_eq("iss_vk",  64'(alu_vk),  64'(e.vk));
        check_eq("iss_a",   64'(alu_a),   64'(e.a));
        check_eq("iss_pc",  64'(alu_pc),  64'(e.pc));
      end
    end
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; clr = 1'b0; rob_head = 4'd0;
    disp_valid = 1'b0; disp_op = 6'd0; disp_a = 32'd0; disp_pc = 32'd0; disp_tag = 4'd0;
    disp_qj_busy = 1'b0; disp_qk_busy = 1'b0; disp_vj = 32'd0; disp_vk = 32'd0;
    cdb_valid = 2'b00; cdb_tag = 8'd0; cdb_value = 64'd0; alu_ready = 1'b1;

    @(posedge clk); #1;
    check_eq("rst_valid", 64'(alu_valid), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_full", 64'(full), 64'd0);
    check_eq("rst_dready", 64'(disp_ready), 64'd1);
    rst = 1'b1;

    // Both operands ready: two edges to alu_valid.
    push_exp(6'h03, 4'd5, 32'd10, 32'd20);
    dispatch(6'h03, 4'd5, 1'b0, 32'd10, 1'b0, 32'd20);
    @(negedge clk);
    check_eq("b_cnt1", 64'(count), 64'd1);
    check_eq("b_val0", 64'(alu_valid), 64'd0);
    @(negedge clk);
    check_eq("b_val1", 64'(alu_valid), 64'd1);
    check_eq("b_cnt0", 64'(count), 64'd0);
    wait_drain(10);

    // Wakeup one cycle after dispatch on channel 1; channel 0 carries same tag but is invalid.
    push_exp(6'h11, 4'd3, 32'h0000_DEAD, 32'd1);
    dispatch(6'h11, 4'd3, 1'b1, 32'd7, 1'b0, 32'd1);
    @(negedge clk);
    check_eq("w_val0", 64'(alu_valid), 64'd0);
    cdb_pulse(2'b10, 4'd7, 4'd7, 32'h0000_DEAD, 32'h0000_BAD0);
    @(negedge clk);
    check_eq("w_val1", 64'(alu_valid), 64'd0);
    @(negedge clk);
    check_eq("w_val2", 64'(alu_valid), 64'd1);
    wait_drain(10);

    // Same-cycle capture at dispatch; both channels hit, channel 0 wins.
    push_exp(6'h12, 4'd4, 32'h111, 32'h111);
    cdb_valid = 2'b11; cdb_tag = {4'd9, 4'd9}; cdb_value = {32'h222, 32'h111};
    dispatch(6'h12, 4'd4, 1'b1, 32'd9, 1'b1, 32'd9);
    cdb_valid = 2'b00;
    @(negedge clk);
    check_eq("s_val0", 64'(alu_valid), 64'd0);
    @(negedge clk);
    check_eq("s_val1", 64'(alu_valid), 64'd1);
    wait_drain(10);

    // Age ordering across ROB wrap: head 14 makes 14 oldest, then 15, then 1.
    rob_head = 4'd14;
    dispatch(6'h20, 4'd1,  1'b1, 32'd10, 1'b0, 32'd0);
    dispatch(6'h20, 4'd15, 1'b1, 32'd10, 1'b0, 32'd0);
    dispatch(6'h20, 4'd14, 1'b1, 32'd10, 1'b0, 32'd0);
    push_exp(6'h20, 4'd14, 32'h55, 32'd0);
    push_exp(6'h20, 4'd15, 32'h55, 32'd0);
    push_exp(6'h20, 4'd1,  32'h55, 32'd0);
    cdb_pulse(2'b01, 4'd0, 4'd10, 32'd0, 32'h55);
    wait_drain(20);

    // Fill all 16 entries, each pending on its own tag.
    for (int i = 0; i < 16; i++) begin
      dispatch(6'h30, 4'(i), 1'b1, 32'(i), 1'b0, 32'd0);
    end
    @(negedge clk);
    check_eq("f_cnt", 64'(count), 64'd16);
    check_eq("f_full", 64'(full), 64'd1);
    check_eq("f_dready", 64'(disp_ready), 64'd0);
    disp_valid = 1'b1; disp_tag = 4'd6; disp_qj_busy = 1'b1; disp_vj = 32'd13;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("f_cnt17", 64'(count), 64'd16);
    push_exp(6'h30, 4'd6, 32'h66, 32'd0);
    cdb_pulse(2'b01, 4'd0, 4'd6, 32'd0, 32'h66);
    @(negedge clk);
    check_eq("f_cntw", 64'(count), 64'd16);
    check_eq("f_valw", 64'(alu_valid), 64'd0);
    @(posedge clk); #1;
    disp_valid = 1'b0;
    @(negedge clk);
    check_eq("f_cnt15", 64'(count), 64'd15);
    check_eq("f_dready1", 64'(disp_ready), 64'd1);
    check_eq("f_full0", 64'(full), 64'd0);
    @(posedge clk); #1;

    // Backpressure: slot holds while alu_ready=0, next entry loads on the accepting edge.
    alu_ready = 1'b0;
    push_exp(6'h30, 4'd0, 32'hA0, 32'd0);
    push_exp(6'h30, 4'd1, 32'hA1, 32'd0);
    cdb_pulse(2'b11, 4'd1, 4'd0, 32'hA1, 32'hA0);
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      check_eq("st_val", 64'(alu_valid), 64'd1);
      check_eq("st_tag", 64'(alu_tag), 64'd0);
      check_eq("st_vj", 64'(alu_vj), 64'hA0);
      check_eq("st_cnt", 64'(count), 64'd14);
    end
    @(posedge clk); #1;
    alu_ready = 1'b1;
    @(posedge clk); #1;
    alu_ready = 1'b0;
    @(negedge clk);
    check_eq("st2_val", 64'(alu_valid), 64'd1);
    check_eq("st2_tag", 64'(alu_tag), 64'd1);
    check_eq("st2_cnt", 64'(count), 64'd13);
    check_eq("st2_q", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) void'(exp_q.pop_front());

    // Flush overrides the same-cycle dispatch and drops the issue slot.
    @(posedge clk); #1;
    clr = 1'b1;
    disp_valid = 1'b1; disp_tag = 4'd2; disp_qj_busy = 1'b0; disp_qk_busy = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0; disp_valid = 1'b0;
    @(negedge clk);
    check_eq("c_cnt", 64'(count), 64'd0);
    check_eq("c_val", 64'(alu_valid), 64'd0);
    alu_ready = 1'b1;
    cdb_pulse(2'b01, 4'd0, 4'd3, 32'd0, 32'h33);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("c_idle", 64'(alu_valid), 64'd0);

    // Global stall: dispatch is not taken.
    rdy = 1'b0;
    dispatch(6'h31, 4'd8, 1'b0, 32'd1, 1'b0, 32'd2);
    @(negedge clk);
    check_eq("r_cnt", 64'(count), 64'd0);
    check_eq("r_val", 64'(alu_valid), 64'd0);
    rdy = 1'b1;

    // Async reset while an issue is pending in the slot.
    alu_ready = 1'b0;
    dispatch(6'h32, 4'd7, 1'b0, 32'd3, 1'b0, 32'd4);
    @(negedge clk);
    check_eq("ar_cnt1", 64'(count), 64'd1);
    @(negedge clk);
    check_eq("ar_val1", 64'(alu_valid), 64'd1);
    check_eq("ar_tag", 64'(alu_tag), 64'd7);
    #1 rst = 1'b0;
    #1;
    check_eq("ar_val0", 64'(alu_valid), 64'd0);
    check_eq("ar_cnt0", 64'(count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    alu_ready = 1'b1;

    wait_drain(10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
